// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle ARM controller (FSM, ALU decoder, NZCV flags, condition check).
// Optional MC_CMP_EN adds CMP (cmd 1010) as a flag-setting SUB with no register write-back.
module mc_control_unit #(
    parameter logic [3:0] NZCV_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [19:0] Instr_fields,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUCtrl
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic        cond_ex_q, cond_ex_d;
    logic [3:0]  cond, cmd, rd;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic        s_bit, l_bit, rd_pc;
    logic [1:0]  alu_dec, flag_w;
    logic        no_write, cond_ex;
    logic        n_f, z_f, c_f, v_f;
    logic        pc_write, reg_write, ir_write, mem_write;
    logic        unused_rn;

    assign cond      = Instr_fields[19:16];
    assign op        = Instr_fields[15:14];
    assign funct     = Instr_fields[13:8];
    assign rd        = Instr_fields[3:0];
    assign unused_rn = ^Instr_fields[7:4];
    assign cmd       = funct[4:1];
    assign s_bit     = funct[0];
    assign l_bit     = funct[0];
    assign rd_pc     = (rd == 4'hf);
    assign {n_f, z_f, c_f, v_f} = flags_q;

    assign RegSrc = {(op == 2'b01) & ~l_bit, (op == 2'b10)};
    assign ImmSrc = op;

    always_comb begin
        alu_dec  = 2'b00;
        no_write = 1'b0;
        flag_w   = {s_bit, 1'b0};
        case (cmd)
            4'b0100: flag_w[0] = s_bit;
            4'b0010: begin
                alu_dec   = 2'b01;
                flag_w[0] = s_bit;
            end
            4'b0000: alu_dec = 2'b10;
            4'b1100: alu_dec = 2'b11;
`ifdef MC_CMP_EN
            4'b1010: begin
                alu_dec  = 2'b01;
                no_write = 1'b1;
                flag_w   = 2'b11;
            end
`endif
            default: begin
                no_write = 1'b1;
                flag_w   = 2'b00;
            end
        endcase
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = z_f;
            4'h1: cond_ex = ~z_f;
            4'h2: cond_ex = c_f;
            4'h3: cond_ex = ~c_f;
            4'h4: cond_ex = n_f;
            4'h5: cond_ex = ~n_f;
            4'h6: cond_ex = v_f;
            4'h7: cond_ex = ~v_f;
            4'h8: cond_ex = c_f & ~z_f;
            4'h9: cond_ex = ~c_f | z_f;
            4'ha: cond_ex = (n_f == v_f);
            4'hb: cond_ex = (n_f != v_f);
            4'hc: cond_ex = ~z_f & (n_f == v_f);
            4'hd: cond_ex = z_f | (n_f != v_f);
            4'he: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= FETCH;
            flags_q   <= NZCV_RESET;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    always_comb begin
        state_d   = FETCH;
        flags_d   = flags_q;
        cond_ex_d = (state_q == DECODE) ? cond_ex : cond_ex_q;
        if ((state_q == EXECR || state_q == EXECI) && cond_ex_q) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE:   state_d = (op == 2'b01) ? MEMADR :
                                (op == 2'b10) ? BRANCH :
                                (op == 2'b00) ? (funct[5] ? EXECI : EXECR) : FETCH;
            MEMADR:   state_d = l_bit ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = MEMWB;
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        pc_write  = 1'b0;
        reg_write = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUCtrl   = 2'b00;
        case (state_q)
            FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = cond_ex_q & ~rd_pc;
                pc_write  = cond_ex_q & ~no_write & rd_pc;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = cond_ex_q;
            end
            EXECR: ALUCtrl = alu_dec;
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUCtrl = alu_dec;
            end
            ALUWB: begin
                reg_write = cond_ex_q & ~no_write & ~rd_pc;
                pc_write  = cond_ex_q & ~no_write & rd_pc;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_write  = cond_ex_q;
            end
            default: ;
        endcase
    end

    // strobes must be inert the moment Reset falls, independent of the state register
    assign PCWrite  = pc_write & Reset;
    assign RegWrite = reg_write & Reset;
    assign IRWrite  = ir_write & Reset;
    assign MemWrite = mem_write & Reset;
endmodule
